// File: rtl/edge_level_rebuild_pkg.sv
// rtl/edge_level_rebuild_pkg.sv - shared types and defaults for edge_level_rebuild
// Purpose: state encoding of the level-rebuild FSM and the default period-counter width.
// Contents: CNT_W_DEF (default counter width), state_t (S_LOW, S_HIGH, S_ERR).
package edge_level_rebuild_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HIGH = 2'd1,
    S_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear and load-one
// Purpose: counts enabled cycles, sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   clock, posedge
//   rst    in   asynchronous active-high reset, cnt -> 0
//   en     in   count enable
//   load1  in   load the value 1 (overrides en)
//   clr    in   load the value 0 (overrides load1 and en)
//   cnt    out  current count, W bits
module sat_cnt
  import edge_level_rebuild_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load1,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= W'(1);
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/edge_level_rebuild.sv
// rtl/edge_level_rebuild.sv - rebuilds a level from edge pulses and measures its periods
// Purpose: receive-side partner of edge_det. Tracks the level with an FSM, times each
//   completed level period, offers it on a valid/ready port and flags protocol errors.
// Ports:
//   clk, rst                  clock (posedge) and asynchronous active-high reset
//   edge_rising/falling/both  one-cycle edge pulses from edge_det
//   dat_o                     rebuilt level (registered)
//   width_o, width_lvl_o      length and level of the period just completed
//   width_vld, width_rdy      handshake for the measurement; held until accepted
//   width_ovf                 sticky: measurement overwritten before acceptance
//   err_o                     sticky: protocol violation, block parked in S_ERR
//   err_clr                   pulse: leaves S_ERR, clears err_o and width_ovf
module edge_level_rebuild
  import edge_level_rebuild_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter bit          INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_rising,
  input  logic             edge_falling,
  input  logic             edge_both,
  output logic             dat_o,
  output logic [CNT_W-1:0] width_o,
  output logic             width_lvl_o,
  output logic             width_vld,
  input  logic             width_rdy,
  output logic             width_ovf,
  output logic             err_o,
  input  logic             err_clr
);

  localparam state_t INIT_STATE = INIT_LEVEL ? S_HIGH : S_LOW;

  state_t           state_q;
  state_t           state_d;
  logic             proto_bad;
  logic             valid_edge;
  logic             err_leave;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // A valid edge is exactly one direction, opposite to the current level,
  // with edge_both agreeing. Anything else while tracking parks the FSM in S_ERR.
  always_comb begin
    state_d    = state_q;
    valid_edge = 1'b0;
    err_leave  = 1'b0;
    proto_bad  = (edge_both != (edge_rising | edge_falling));
    case (state_q)
      S_LOW: begin
        if (proto_bad || edge_falling) begin
          state_d = S_ERR;
        end else if (edge_rising) begin
          state_d    = S_HIGH;
          valid_edge = 1'b1;
        end
      end
      S_HIGH: begin
        if (proto_bad || edge_rising) begin
          state_d = S_ERR;
        end else if (edge_falling) begin
          state_d    = S_LOW;
          valid_edge = 1'b1;
        end
      end
      S_ERR: begin
        // Resume tracking from whatever level was held when the error hit.
        if (err_clr) begin
          state_d   = dat_o ? S_HIGH : S_LOW;
          err_leave = 1'b1;
        end
      end
      default: state_d = INIT_STATE;
    endcase
  end

  assign err_o = (state_q == S_ERR);

  // Counter freezes while in S_ERR and restarts from 0 when the error is cleared.
  sat_cnt #(
    .W(CNT_W)
  ) u_sat_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != S_ERR),
    .load1(valid_edge),
    .clr  (err_leave),
    .cnt  (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_o <= INIT_LEVEL;
    end else if (valid_edge) begin
      dat_o <= ~dat_o;
    end
  end

  // Measurement holding register. A new load takes priority over the handshake
  // drop, so an accept and a load in the same cycle keep width_vld high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_o     <= '0;
      width_lvl_o <= 1'b0;
      width_vld   <= 1'b0;
    end else if (valid_edge) begin
      width_o     <= cnt;
      width_lvl_o <= dat_o;
      width_vld   <= 1'b1;
    end else if (width_vld && width_rdy) begin
      width_vld <= 1'b0;
    end
  end

  // An overwrite in the same cycle as err_clr still leaves the flag set,
  // since that measurement was genuinely lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_ovf <= 1'b0;
    end else if (valid_edge && width_vld && !width_rdy) begin
      width_ovf <= 1'b1;
    end else if (err_clr) begin
      width_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_level_rebuild.sv
// tb/tb_edge_level_rebuild.sv - scoreboard bench for edge_level_rebuild
module tb_edge_level_rebuild;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          edge_rising = 1'b0;
  logic          edge_falling = 1'b0;
  logic          edge_both = 1'b0;
  logic          dat_o;
  logic [CW-1:0] width_o;
  logic          width_lvl_o;
  logic          width_vld;
  logic          width_rdy = 1'b0;
  logic          width_ovf;
  logic          err_o;
  logic          err_clr = 1'b0;

  edge_level_rebuild #(
    .CNT_W(CW),
    .INIT_LEVEL(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .edge_rising (edge_rising),
    .edge_falling(edge_falling),
    .edge_both   (edge_both),
    .dat_o       (dat_o),
    .width_o     (width_o),
    .width_lvl_o (width_lvl_o),
    .width_vld   (width_vld),
    .width_rdy   (width_rdy),
    .width_ovf   (width_ovf),
    .err_o       (err_o),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   w;
    logic lvl;
  } meas_t;

  meas_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: level, error flag, overflow flag, one-slot pending measurement.
  logic m_level, m_err, m_ovf, m_pend;
  int   cyc, t_last;
  // Values the DUT should show during the current cycle.
  logic exp_dat, exp_err, exp_ovf, exp_vld;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dat", dat_o, 0);
      chk("rst_width", width_o, 0);
      chk("rst_lvl", width_lvl_o, 0);
      chk("rst_vld", width_vld, 0);
      chk("rst_ovf", width_ovf, 0);
      chk("rst_err", err_o, 0);
    end else begin
      chk("dat_o", dat_o, exp_dat);
      chk("err_o", err_o, exp_err);
      chk("width_ovf", width_ovf, exp_ovf);
      chk("width_vld", width_vld, exp_vld);
      if (width_vld && width_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_meas", 1, 0);
        end else begin
          meas_t m;
          m = exp_q.pop_front();
          chk("width_o", width_o, m.w);
          chk("width_lvl_o", width_lvl_o, m.lvl);
        end
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_level = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_pend = 1'b0;
    cyc = 0; t_last = 0;
    exp_dat = 1'b0; exp_err = 1'b0; exp_ovf = 1'b0; exp_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    edge_rising = 1'b0; edge_falling = 1'b0; edge_both = 1'b0;
    width_rdy = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Drive one cycle of inputs and advance the model by that cycle's clock edge.
  task automatic step(input logic r, input logic f, input logic b,
                      input logic rdy, input logic clr);
    logic bad, loaded;
    int   w;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_dat = m_level; exp_err = m_err; exp_ovf = m_ovf; exp_vld = m_pend;
    edge_rising = r; edge_falling = f; edge_both = b;
    width_rdy = rdy; err_clr = clr;
    loaded = 1'b0;
    if (m_err) begin
      if (clr) begin
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        t_last = cyc + 1;
      end
    end else begin
      if (clr) m_ovf = 1'b0;
      bad = (b != (r | f)) || (r && f) || (m_level ? r : f);
      if (bad) begin
        m_err = 1'b1;
      end else if (b) begin
        w = cyc - t_last;
        if (w > CNT_MAX) w = CNT_MAX;
        if (m_pend && !rdy) begin
          m_ovf = 1'b1;
          void'(exp_q.pop_back());
        end
        exp_q.push_back('{w: w, lvl: m_level});
        m_pend  = 1'b1;
        m_level = ~m_level;
        t_last  = cyc;
        loaded  = 1'b1;
      end
    end
    if (!loaded && m_pend && rdy) m_pend = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic rand_step();
    logic r, f, b, rdy, clr;
    int   k;
    r = 1'b0; f = 1'b0; b = 1'b0; clr = 1'b0;
    rdy = 1'($urandom_range(0, 1));
    if (m_err) begin
      r = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 3) == 0);
    end else begin
      k = $urandom_range(0, 99);
      if (k < 3) begin
        case ($urandom_range(0, 3))
          0: begin if (m_level) r = 1'b1; else f = 1'b1; b = 1'b1; end
          1: begin r = 1'b1; f = 1'b1; b = 1'b1; end
          2: begin if (m_level) f = 1'b1; else r = 1'b1; end
          default: b = 1'b1;
        endcase
      end else if (k < 15) begin
        if (m_level) f = 1'b1; else r = 1'b1;
        b = 1'b1;
      end
      clr = ($urandom_range(0, 39) == 0);
    end
    step(r, f, b, rdy, clr);
  endtask

  initial begin
    model_reset();

    // Rise at 5, fall at 12: periods of 5 (low) and 7 (high).
    do_reset();
    for (int c = 0; c <= 14; c++)
      step(c == 5, c == 12, (c == 5) || (c == 12), 1'b1, 1'b0);

    // Consumer stalled across three edges: overwrites and sticky overflow, then clear.
    do_reset();
    for (int c = 0; c <= 34; c++)
      step((c == 20) || (c == 30), c == 23, (c == 20) || (c == 23) || (c == 30), 1'b0, c == 33);
    idle(3, 1'b1);

    // Redundant rising edge, ignored edges while in error, clear then a timed fall.
    do_reset();
    for (int c = 0; c <= 17; c++)
      step((c == 2) || (c == 6) || (c == 9), c == 9, (c == 2) || (c == 6) || (c == 9),
           1'b1, c == 12);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Rising without edge_both, then simultaneous rising and falling.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Long high period saturates the counter.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(40, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Random traffic, reset pulsed between segments while activity is in flight.
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 600; i++) rand_step();
      if (seg != 3) do_reset();
    end

    idle(20, 1'b1);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
